// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the bit-serial adder family.
//   sadd_state_t    : serial_adder control states (IDLE / SHIFT / DONE)
//   sadd_cnt_width  : bit-counter width for a given operand width
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sadd_state_t;

    // clog2(width)+1 keeps the counter at least one bit wide, so a 1-bit
    // adder still has a (trivially zero) counter to compare against.
    function automatic int sadd_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder built from two half-adder cells and an OR for the carry.
// Ports:
//   i_a, i_b : operand bits
//   i_c      : carry in
//   o_s      : sum bit
//   o_c      : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (
        .i_a (i_a),
        .i_b (i_b),
        .o_s (w_s0),
        .o_c (w_c0)
    );

    half_adder u_ha1 (
        .i_a (w_s0),
        .i_b (i_c),
        .o_s (o_s),
        .o_c (w_c1)
    );

    // The two half-adder carries can never both be set, so OR is exact.
    assign o_c = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
// Combinational half-adder cell, the arithmetic primitive of the serial adder.
// Ports:
//   i_a, i_b : input bits
//   o_s      : sum bit   (i_a ^ i_b)
//   o_c      : carry bit (i_a & i_b)
// -----------------------------------------------------------------------------
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder: sum = a + b + cin, one bit per clock, LSB first,
// with a single registered carry. Start/done handshake.
// Parameters:
//   WIDTH : operand / result width, 1..32
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only in IDLE
//   a, b   : operands, captured on the accepting edge
//   cin    : carry-in, captured on the accepting edge
//   busy   : high while bits are being processed
//   done   : one-cycle pulse when sum/cout are valid
//   sum    : registered result, held until the next completion
//   cout   : registered carry-out, held with sum
// -----------------------------------------------------------------------------
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = sadd_cnt_width(WIDTH);

    sadd_state_t      r_state;
    sadd_state_t      w_state_nxt;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_acc_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_nxt;

    full_adder u_fa (
        .i_a (r_a_sr[0]),
        .i_b (r_b_sr[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    // A 1-bit accumulator has no upper part to keep.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign w_acc_nxt = w_s;
        end else begin : g_acc_wn
            assign w_acc_nxt = {w_s, r_acc_sr[WIDTH-1:1]};
        end
    endgenerate

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // ---------------- control: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath: shift registers, carry, result ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_acc_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_acc_sr <= w_acc_nxt;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sum  <= w_acc_nxt;
                        r_cout <= w_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // busy/done decode straight from state, so reset clears them immediately
    // and they can never be high together.
    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
